ram_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 128×8 RAM (`ram_single`) between two independent clients. It accepts requests over a req/ack handshake and serialises them onto the RAM's single address/data/write-enable port with round-robin fairness. It returns read data to the owning client. It sits between the client logic and `ram_single`, which it owns exclusively.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arb_rr_pick2.sv | 30 +++
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arb_rr_pick2.sv
// Combinational 2-way picker: round-robin on ties, or fixed priority to port 0
// when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    assign valid = |eligible;

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    assign grant       = eligible[0] ? PORT0 : PORT1;
`else
    always_comb begin
        grant = PORT0;
        if (eligible[0] && eligible[1]) begin
            // Tie goes to whichever port was not served most recently.
            grant = (last == PORT0) ? PORT1 : PORT0;
        end else if (eligible[1]) begin
            grant = PORT1;
        end
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port synchronous RAM between two req/ack clients, one access
// per three cycles. Define RAM_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [DATA_W-1:0] ram_d_q, ram_d_d;
    logic              ram_we_q, ram_we_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]        eligible;
    logic              pick_grant, pick_valid;

    // A request still held during its own ack cycle must not be served twice.
    assign eligible = {req1 & ~ack1_q, req0 & ~ack0_q};

    rr_pick2 u_pick (
        .eligible (eligible),
        .last     (last_q),
        .grant    (pick_grant),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        cmd_we_d = cmd_we_q;
        ram_a_d  = ram_a_q;
        ram_d_d  = ram_d_q;
        ram_we_d = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_grant;
                    last_d  = pick_grant;
                    if (pick_grant == PORT1) begin
                        cmd_we_d = we1;
                        ram_a_d  = addr1;
                        ram_d_d  = wdata1;
                    end else begin
                        cmd_we_d = we0;
                        ram_a_d  = addr0;
                        ram_d_d  = wdata0;
                    end
                    ram_we_d = cmd_we_d;
                end
            end
            CAPTURE: begin
                // ram_q now holds the word sampled at the ACCESS edge.
                if (owner_q == PORT1) begin
                    ack1_d = 1'b1;
                    if (!cmd_we_q) rdata1_d = ram_q;
                end else begin
                    ack0_d = 1'b1;
                    if (!cmd_we_q) rdata0_d = ram_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= PORT0;
            last_q   <= PORT1;
            cmd_we_q <= 1'b0;
            ram_a_q  <= '0;
            ram_d_q  <= '0;
            ram_we_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            owner_q  <= owner_d;
            last_q   <= last_d;
            cmd_we_q <= cmd_we_d;
            ram_a_q  <= ram_a_d;
            ram_d_q  <= ram_d_d;
            ram_we_q <= ram_we_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign ram_a  = ram_a_q;
    assign ram_d  = ram_d_q;
    assign ram_we = ram_we_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random
// traffic against a transaction-timeline reference model and a RAM model.
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req, we;
    logic [6:0] addr [2];
    logic [7:0] wdata [2];
    logic       ack0, ack1, ram_we;
    logic [7:0] rdata0, rdata1, ram_d, ram_q;
    logic [6:0] ram_a;

    ram_port_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req[0]),
        .req1   (req[1]),
        .we0    (we[0]),
        .we1    (we[1]),
        .addr0  (addr[0]),
        .addr1  (addr[1]),
        .wdata0 (wdata[0]),
        .wdata1 (wdata[1]),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .ram_a  (ram_a),
        .ram_d  (ram_d),
        .ram_we (ram_we),
        .ram_q  (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-before-write.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        ram_q <= mem[ram_a];
        if (ram_we) mem[ram_a] = ram_d;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each grant at edge g performs the RAM access at g+1,
    // raises ack after edge g+2, and the next grant may happen at g+3.
    logic [7:0] ref_mem [128];
    logic [7:0] exp_rd [2];
    int         n, free_at, grant_edge, acc_edge, ack_edge;
    bit         last, cur_port, cur_we;
    logic [6:0] cur_addr;
    logic [7:0] cur_wdata, cur_rval;
    int         obs_q [$];

    function automatic void model_reset();
        free_at    = 0;
        grant_edge = -10;
        acc_edge   = -10;
        ack_edge   = -10;
        last       = 1'b1;
        exp_rd[0]  = 8'h00;
        exp_rd[1]  = 8'h00;
    endfunction

    task automatic step();
        bit av0, av1, e0, e1, w;
        @(posedge clk);
        n++;
        if (!rst_n) begin
            model_reset();
        end else begin
            av0 = (ack_edge == n - 1) && (cur_port == 1'b0);
            av1 = (ack_edge == n - 1) && (cur_port == 1'b1);
            if (acc_edge == n) begin
                if (cur_we) ref_mem[cur_addr] = cur_wdata;
                else        cur_rval = ref_mem[cur_addr];
            end
            if (ack_edge == n && !cur_we) exp_rd[cur_port] = cur_rval;
            e0 = req[0] && !av0;
            e1 = req[1] && !av1;
            if (n >= free_at && (e0 || e1)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                w = e0 ? 1'b0 : 1'b1;
`else
                w = (e0 && e1) ? !last : e1;
`endif
                last       = w;
                cur_port   = w;
                cur_we     = we[w];
                cur_addr   = addr[w];
                cur_wdata  = wdata[w];
                grant_edge = n;
                acc_edge   = n + 1;
                ack_edge   = n + 2;
                free_at    = n + 3;
            end
        end
        #1;
        check("ack0", ack0, (ack_edge == n) && (cur_port == 1'b0));
        check("ack1", ack1, (ack_edge == n) && (cur_port == 1'b1));
        check("ram_we", ram_we, (grant_edge == n) && cur_we);
        check("rdata0", rdata0, exp_rd[0]);
        check("rdata1", rdata1, exp_rd[1]);
        if (grant_edge == n) begin
            check("ram_a", ram_a, cur_addr);
            if (cur_we) check("ram_d", ram_d, cur_wdata);
        end
        if (ack0) obs_q.push_back(0);
        if (ack1) obs_q.push_back(1);
    endtask

    task automatic do_txn(input int p, input logic w, input logic [6:0] a,
                          input logic [7:0] d, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        while (!got && lat < 12) begin
            step();
            lat++;
            got = (p == 0) ? ack0 : ack1;
        end
        req[p] = 1'b0;
        check("txn_ack", got, 1'b1);
    endtask

    task automatic new_req(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(1, 0));
        addr[p]  = 7'h78 + 7'($urandom_range(7, 0));
        wdata[p] = 8'($urandom);
    endtask

    task automatic rand_drive();
        logic a;
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? ack0 : ack1;
            if (req[p] && a) begin
                if ($urandom_range(1, 0) == 0) req[p] = 1'b0;
                else                           new_req(p);
            end else if (!req[p] && $urandom_range(9, 0) < 4) begin
                new_req(p);
            end
        end
    endtask

    initial begin
        int lat, t0, t1, nack;
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        n = 0;
        cur_port = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_wdata = '0; cur_rval = '0;
        model_reset();
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset held with both clients requesting
        req = 2'b11; we = 2'b11;
        addr[0] = 7'h30; wdata[0] = 8'h11; addr[1] = 7'h31; wdata[1] = 8'h22;
        repeat (3) step();
        check("rst_ram_a", ram_a, 7'h00);
        check("rst_ram_d", ram_d, 8'h00);
        rst_n = 1'b1;
        obs_q.delete();
        t0 = 0; t1 = 0;
        for (int c = 1; c <= 12 && req != 2'b00; c++) begin
            step();
            if (ack0) begin t0 = c; req[0] = 1'b0; end
            if (ack1) begin t1 = c; req[1] = 1'b0; end
        end
        check("first_grant_t0", t0, 3);
        check("first_grant_t1", t1, 6);

        // Write then cross-port read of 7'h79
        do_txn(0, 1'b1, 7'h79, 8'b11001100, lat);
        do_txn(1, 1'b0, 7'h79, 8'h00, lat);
        check("rd79_lat", lat, 3);
        check("rd79_data", rdata1, 8'b11001100);

        // Simultaneous writes, then readback
        req = 2'b11; we = 2'b11;
        addr[0] = 7'h7D; wdata[0] = 8'b10101010;
        addr[1] = 7'h7B; wdata[1] = 8'b00001111;
        t0 = 0; t1 = 0;
        for (int c = 1; c <= 12 && req != 2'b00; c++) begin
            step();
            if (ack0) begin t0 = c; req[0] = 1'b0; end
            if (ack1) begin t1 = c; req[1] = 1'b0; end
        end
        check("tie_t0", t0, 3);
        check("tie_t1", t1, 6);
        do_txn(0, 1'b0, 7'h7D, 8'h00, lat);
        check("rb7d", rdata0, 8'b10101010);
        do_txn(1, 1'b0, 7'h7B, 8'h00, lat);
        check("rb7b", rdata1, 8'b00001111);

        // Both reqs held for six grants. A port is ineligible in its own ack
        // cycle, so the other port takes every next slot and grants alternate.
        req = 2'b11; we = 2'b11;
        addr[0] = 7'h10; wdata[0] = 8'h5C; addr[1] = 7'h11; wdata[1] = 8'hC5;
        obs_q.delete();
        repeat (18) step();
        req = 2'b00;
        repeat (3) step();
        check("rr_count", obs_q.size(), 6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            check($sformatf("rr_order%0d", i), obs_q[i], i % 2);
        end

        // Request held through its ack cycle only: exactly one access
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 7'h79;
        nack = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (ack0) nack++;
            if (c == 4) req[0] = 1'b0;
        end
        check("hold_once", nack, 1);

        // Held one cycle past ack: a second access follows
        req[0] = 1'b1;
        nack = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (ack0) nack++;
            if (c == 5) req[0] = 1'b0;
        end
        check("hold_twice", nack, 2);

        // Reset during ACCESS of a write aborts it
        do_txn(1, 1'b1, 7'h7F, 8'h5A, lat);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 7'h7F; wdata[0] = 8'b11110000;
        step();
        check("abort_we_pre", ram_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we_drop", ram_we, 1'b0);
        check("abort_ack0", ack0, 1'b0);
        model_reset();
        req = 2'b00;
        repeat (2) step();
        rst_n = 1'b1;
        do_txn(0, 1'b0, 7'h7F, 8'h00, lat);
        check("abort_keep", rdata0, 8'h5A);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            step();
            rand_drive();
        end
        req = 2'b00;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
